// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the raster engine.
package vga_pkg;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BP     = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BP     = 23;

  function automatic int vga_total(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Window/select controls in, video timing and colour out.
interface vga_timing_gen_if #(
  parameter int CW      = 11,
  parameter int COLOR_W = 4
);
  logic [CW-1:0]      win_x0;
  logic [CW-1:0]      win_x1;
  logic [CW-1:0]      win_y0;
  logic [CW-1:0]      win_y1;
  logic               sel_r;
  logic               sel_g;
  logic               sel_b;
  logic               hs;
  logic               vs;
  logic               de;
  logic [CW-1:0]      x;
  logic [CW-1:0]      y;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;
  logic               frame_start;

  modport master (
    output win_x0, win_x1, win_y0, win_y1, sel_r, sel_g, sel_b,
    input  hs, vs, de, x, y, r, g, b, frame_start
  );

  modport slave (
    input  win_x0, win_x1, win_y0, win_y1, sel_r, sel_g, sel_b,
    output hs, vs, de, x, y, r, g, b, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on enable and flags the last position.
module vga_axis_counter #(
  parameter int W     = 11,
  parameter int TOTAL = 800
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  assign term = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (en)
      cnt <= term ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster engine: pixel divider, H/V counters, sync/DE generation and
// a frame-synchronous windowed solid-colour fill, all outputs registered.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 4,
  parameter int CW       = 11
) (
  input logic             clk,
  input logic             rst,
  vga_timing_gen_if.slave vif
);
  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic               pix_ce;
  logic [CW-1:0]      hc, vc;
  logic               h_term, v_term;
  logic [CW-1:0]      sx0, sx1, sy0, sy1;
  logic               active, in_win, hs_n, vs_n;
  logic [COLOR_W-1:0] r_n, g_n, b_n;

  generate
    if (CLK_DIV == 1) begin : g_nodiv
      assign pix_ce = 1'b1;
    end else begin : g_div
      logic [DW-1:0] div;
      assign pix_ce = (div == DW'(CLK_DIV - 1));
      always_ff @(posedge clk) begin
        if (rst || pix_ce) div <= '0;
        else               div <= div + DW'(1);
      end
    end
  endgenerate

  vga_axis_counter #(.W(CW), .TOTAL(H_TOTAL)) u_hcnt (
    .clk(clk), .rst(rst), .en(pix_ce), .cnt(hc), .term(h_term)
  );

  vga_axis_counter #(.W(CW), .TOTAL(V_TOTAL)) u_vcnt (
    .clk(clk), .rst(rst), .en(pix_ce & h_term), .cnt(vc), .term(v_term)
  );

  assign active = (hc < H_ACT) && (vc < V_ACT);
  assign in_win = active && (hc >= sx0) && (hc <= sx1) && (vc >= sy0) && (vc <= sy1);
  assign hs_n   = ((hc >= HS_BEG) && (hc < HS_END)) ? HS_POL : ~HS_POL;
  assign vs_n   = ((vc >= VS_BEG) && (vc < VS_END)) ? VS_POL : ~VS_POL;

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (in_win) begin
      if (vif.sel_r)      r_n = '1;
      else if (vif.sel_g) g_n = '1;
      else if (vif.sel_b) b_n = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vif.hs          <= ~HS_POL;
      vif.vs          <= ~VS_POL;
      vif.de          <= 1'b0;
      vif.x           <= '0;
      vif.y           <= '0;
      vif.r           <= '0;
      vif.g           <= '0;
      vif.b           <= '0;
      vif.frame_start <= 1'b0;
      sx0 <= '0;
      sx1 <= '0;
      sy0 <= '0;
      sy1 <= '0;
    end else begin
      vif.frame_start <= pix_ce && (hc == '0) && (vc == '0);
      if (pix_ce) begin
        vif.hs <= hs_n;
        vif.vs <= vs_n;
        vif.de <= active;
        vif.x  <= active ? hc : '0;
        vif.y  <= active ? vc : '0;
        vif.r  <= r_n;
        vif.g  <= g_n;
        vif.b  <= b_n;
        // Window only moves between frames so a live update cannot tear the image.
        if (h_term && v_term) begin
          sx0 <= vif.win_x0;
          sx1 <= vif.win_x1;
          sy0 <= vif.win_y0;
          sy1 <= vif.win_y1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a tiny 8x4 raster, cycle-checked against a
// pixel-index reference model plus per-frame colour/timing tallies.
module tb_vga_timing_gen;
  localparam int CW = 11, COLOR_W = 4;
  localparam int HA = 8, HF = 2, HSY = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int HT = 14, VT = 7, FR = HT * VT, DIV = 2;
  localparam int BOUND = 2 * FR * DIV + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(CW), .COLOR_W(COLOR_W)) vif ();
  vga_timing_gen_if #(.CW(CW), .COLOR_W(COLOR_W)) vif1 ();

  assign vif1.win_x0 = vif.win_x0;
  assign vif1.win_x1 = vif.win_x1;
  assign vif1.win_y0 = vif.win_y0;
  assign vif1.win_y1 = vif.win_y1;
  assign vif1.sel_r  = vif.sel_r;
  assign vif1.sel_g  = vif.sel_g;
  assign vif1.sel_b  = vif.sel_b;

  vga_timing_gen #(
    .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(COLOR_W), .CW(CW)
  ) dut (.clk(clk), .rst(rst), .vif(vif));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(COLOR_W), .CW(CW)
  ) dut1 (.clk(clk), .rst(rst), .vif(vif1));

  int n_checks = 0, n_pass = 0;

  // reference model state: clocks since reset release and the frame window
  int c = 0, cyc = 0;
  int m_x0 = 0, m_x1 = 0, m_y0 = 0, m_y1 = 0;
  logic e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_fs = 1'b0;
  logic [CW-1:0] e_x = '0, e_y = '0;
  logic [COLOR_W-1:0] e_r = '0, e_g = '0, e_b = '0;
  bit last_ce = 0;
  int last_h = 0, last_v = 0;

  bit counting = 0;
  int pixels, cr, cg, cb, cde, chs, cvs;
  int fs1_q[$];

  typedef struct {
    int x0, x1, y0, y1;
    bit sr, sg, sb;
    int er, eg, eb;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic set_win(input int x0, input int x1, input int y0, input int y1);
    vif.win_x0 = CW'(x0);
    vif.win_x1 = CW'(x1);
    vif.win_y0 = CW'(y0);
    vif.win_y1 = CW'(y1);
  endtask

  task automatic step();
    int n, h, v;
    bit inwin;
    last_ce = 0;
    if (rst) begin
      c = 0;
      m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0;
      e_x = '0; e_y = '0; e_r = '0; e_g = '0; e_b = '0;
    end else begin
      n = c / DIV;
      e_fs = 1'b0;
      if ((c % DIV) == DIV - 1) begin
        h = n % HT;
        v = (n / HT) % VT;
        e_hs = !(h >= HA + HF && h < HA + HF + HSY);
        e_vs = !(v >= VA + VF && v < VA + VF + VSY);
        e_de = (h < HA) && (v < VA);
        e_x  = e_de ? CW'(h) : '0;
        e_y  = e_de ? CW'(v) : '0;
        inwin = e_de && h >= m_x0 && h <= m_x1 && v >= m_y0 && v <= m_y1;
        e_r = (inwin && vif.sel_r) ? '1 : '0;
        e_g = (inwin && !vif.sel_r && vif.sel_g) ? '1 : '0;
        e_b = (inwin && !vif.sel_r && !vif.sel_g && vif.sel_b) ? '1 : '0;
        e_fs = (h == 0) && (v == 0);
        if (h == HT - 1 && v == VT - 1) begin
          m_x0 = int'(vif.win_x0); m_x1 = int'(vif.win_x1);
          m_y0 = int'(vif.win_y0); m_y1 = int'(vif.win_y1);
        end
        last_ce = 1; last_h = h; last_v = v;
      end
      c++;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("outputs", 64'({vif.hs, vif.vs, vif.de, vif.x, vif.y, vif.r, vif.g, vif.b, vif.frame_start}),
                   64'({e_hs, e_vs, e_de, e_x, e_y, e_r, e_g, e_b, e_fs}));
    if (vif1.frame_start) fs1_q.push_back(cyc);
    if (counting && last_ce) begin
      pixels++;
      if (vif.r != '0) cr++;
      if (vif.g != '0) cg++;
      if (vif.b != '0) cb++;
      if (vif.de) cde++;
      if (!vif.hs) chs++;
      if (!vif.vs) cvs++;
    end
  endtask

  task automatic clear_counts();
    pixels = 0; cr = 0; cg = 0; cb = 0; cde = 0; chs = 0; cvs = 0;
  endtask

  task automatic sync_capture();
    int k = 0;
    do begin step(); k++; end
    while (!(last_ce && last_h == HT - 1 && last_v == VT - 1) && k < BOUND);
    chk("sync_capture_reached", 64'(last_ce && last_h == HT - 1 && last_v == VT - 1), 64'd1);
  endtask

  task automatic count_frame();
    int k = 0;
    clear_counts();
    counting = 1;
    while (pixels < FR && k < BOUND) begin step(); k++; end
    counting = 0;
    chk("frame_pixels", 64'(pixels), 64'(FR));
  endtask

  initial begin
    int k;
    vecs[0] = '{2, 5, 1, 2, 0, 1, 0, 0, 8, 0};
    vecs[1] = '{0, 7, 0, 3, 0, 1, 0, 0, 32, 0};
    vecs[2] = '{0, 7, 0, 3, 1, 0, 1, 32, 0, 0};
    vecs[3] = '{6, 3, 0, 3, 0, 1, 0, 0, 0, 0};
    vecs[4] = '{1, 1, 3, 3, 0, 0, 1, 0, 0, 1};
    vecs[5] = '{6, 12, 2, 6, 1, 0, 0, 4, 0, 0};
    vecs[6] = '{0, 7, 0, 3, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{3, 3, 0, 3, 0, 1, 1, 0, 4, 0};

    set_win(0, 0, 0, 0);
    vif.sel_r = 0; vif.sel_g = 0; vif.sel_b = 0;

    // reset for 3 clocks, then both DUTs start their rasters
    rst = 1;
    repeat (3) step();
    chk("div1_rst_hs", 64'(vif1.hs), 64'd1);
    chk("div1_rst_de", 64'(vif1.de), 64'd0);
    rst = 0;
    step();
    chk("div1_first_fs", 64'(vif1.frame_start), 64'd1);
    chk("div2_no_fs_yet", 64'(vif.frame_start), 64'd0);
    step();
    chk("div1_x_every_clk", 64'(vif1.x), 64'd1);
    chk("div2_first_fs", 64'(vif.frame_start), 64'd1);
    step();
    chk("div1_x_next", 64'(vif1.x), 64'd2);

    k = 0;
    do begin step(); k++; end while (!vif.frame_start && k < BOUND);
    chk("frame_period_clks", 64'(k + 1), 64'(FR * DIV));
    chk("div1_frame_period", 64'(fs1_q.size() >= 2 ? fs1_q[1] - fs1_q[0] : -1), 64'(FR));

    // two free-running frames: sync and DE occupancy
    for (int f = 0; f < 2; f++) begin
      sync_capture();
      count_frame();
      chk("de_pixels", 64'(cde), 64'd32);
      chk("hs_low_pixels", 64'(chs), 64'(2 * VT));
      chk("vs_low_pixels", 64'(cvs), 64'(HT));
    end

    // window/select table
    foreach (vecs[i]) begin
      set_win(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1);
      vif.sel_r = vecs[i].sr; vif.sel_g = vecs[i].sg; vif.sel_b = vecs[i].sb;
      sync_capture();
      count_frame();
      chk($sformatf("vec%0d_r", i), 64'(cr), 64'(vecs[i].er));
      chk($sformatf("vec%0d_g", i), 64'(cg), 64'(vecs[i].eg));
      chk($sformatf("vec%0d_b", i), 64'(cb), 64'(vecs[i].eb));
    end

    // mid-frame window change must wait for the next frame
    set_win(2, 5, 1, 2);
    vif.sel_r = 0; vif.sel_g = 1; vif.sel_b = 0;
    sync_capture();
    clear_counts();
    counting = 1;
    k = 0;
    while (pixels < FR && k < BOUND) begin
      if (pixels == 30) set_win(0, 7, 0, 3);
      step();
      k++;
    end
    counting = 0;
    chk("midframe_old_window", 64'(cg), 64'd8);
    count_frame();
    chk("next_frame_full_green", 64'(cg), 64'd32);

    // reset in the middle of a line
    k = 0;
    do begin step(); k++; end while (!(last_ce && last_h == 4 && last_v == 2) && k < BOUND);
    chk("reach_mid_line", 64'(last_h * 16 + last_v), 64'(4 * 16 + 2));
    rst = 1;
    step();
    chk("midrst_hs", 64'(vif.hs), 64'd1);
    chk("midrst_g", 64'(vif.g), 64'd0);
    rst = 0;
    k = 0;
    do begin step(); k++; end while (!vif.frame_start && k < 8);
    chk("restart_fs_latency", 64'(k), 64'd2);
    chk("restart_xy", 64'({vif.x, vif.y}), 64'd0);

    // randomized run with occasional window updates and resets
    for (int i = 0; i < 4 * FR * DIV; i++) begin
      {vif.sel_r, vif.sel_g, vif.sel_b} = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0)
        set_win($urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 7), $urandom_range(0, 7));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
